// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot loader: byte stream with length header to 32-bit instruction memory writes
module instr_mem_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter logic [31:0] MEM_SIZE_BYTES = 32'h0001_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [31:0] write_addr_o,
   output logic [31:0] write_data_o,
   output logic        write_enable_o,
   output logic        core_rst_o,
   output logic        done_o,
   output logic        error_o
);

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      DATA  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   // last idle count before the abort fires, so the abort lands on the TIMEOUT_CYCLES-th idle edge
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] len_q, len_d;
   logic [1:0]  hdr_cnt_q, hdr_cnt_d;
   logic [31:0] remaining_q, remaining_d;
   logic [1:0]  byte_pos_q, byte_pos_d;
   logic [31:0] word_idx_q, word_idx_d;
   logic [31:0] buffer_q, buffer_d;
   logic [31:0] timer_q, timer_d;
   logic        we_d;
   logic [31:0] addr_d, data_d;
   logic        accept;

   assign rx_ready_o = (state_q != WRITE);
   assign accept     = rx_valid_i && rx_ready_o;
   assign core_rst_o = (state_q != DONE);
   assign done_o     = (state_q == DONE);
   assign error_o    = (state_q == ERROR);

   // state and datapath registers; the write port outputs are registered alongside the FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= HDR;
         len_q          <= '0;
         hdr_cnt_q      <= '0;
         remaining_q    <= '0;
         byte_pos_q     <= '0;
         word_idx_q     <= '0;
         buffer_q       <= '0;
         timer_q        <= '0;
         write_enable_o <= 1'b0;
         write_addr_o   <= BASE_ADDR;
         write_data_o   <= '0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         hdr_cnt_q      <= hdr_cnt_d;
         remaining_q    <= remaining_d;
         byte_pos_q     <= byte_pos_d;
         word_idx_q     <= word_idx_d;
         buffer_q       <= buffer_d;
         timer_q        <= timer_d;
         write_enable_o <= we_d;
         write_addr_o   <= addr_d;
         write_data_o   <= data_d;
      end
   end

   // next-state logic: header parse, byte packing, write issue and idle timeout
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      hdr_cnt_d   = hdr_cnt_q;
      remaining_d = remaining_q;
      byte_pos_d  = byte_pos_q;
      word_idx_d  = word_idx_q;
      buffer_d    = buffer_q;
      timer_d     = timer_q;
      we_d        = 1'b0;
      addr_d      = write_addr_o;
      data_d      = write_data_o;

      case (state_q)
         HDR: begin
            if (accept) begin
               len_d     = {rx_data_i, len_q[31:8]};
               hdr_cnt_d = hdr_cnt_q + 2'd1;
               timer_d   = '0;
               if (hdr_cnt_q == 2'd3) begin
                  remaining_d = len_d;
                  if (len_d == 32'd0)
                     state_d = DONE;
                  else if (len_d > MEM_SIZE_BYTES)
                     state_d = ERROR;
                  else
                     state_d = DATA;
               end
            end else if (hdr_cnt_q != 2'd0) begin
               // a stream that never started is not a stalled load
               if (timer_q == TIMEOUT_LAST)
                  state_d = ERROR;
               else
                  timer_d = timer_q + 32'd1;
            end
         end
         DATA: begin
            if (accept) begin
               buffer_d[{byte_pos_q, 3'b000} +: 8] = rx_data_i;
               remaining_d = remaining_q - 32'd1;
               byte_pos_d  = byte_pos_q + 2'd1;
               timer_d     = '0;
               if (byte_pos_q == 2'd3 || remaining_q == 32'd1) begin
                  state_d = WRITE;
                  we_d    = 1'b1;
                  addr_d  = BASE_ADDR + {word_idx_q[29:0], 2'b00};
                  data_d  = buffer_d;
               end
            end else if (timer_q == TIMEOUT_LAST) begin
               // the partial word is dropped on abort
               state_d = ERROR;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         WRITE: begin
            word_idx_d = word_idx_q + 32'd1;
            buffer_d   = '0;
            byte_pos_d = '0;
            state_d    = (remaining_q == 32'd0) ? DONE : DATA;
         end
         DONE: begin
            state_d = DONE;
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = ERROR;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - testbench for instr_mem_loader
module tb_instr_mem_loader;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        rx_ready_o;
   logic [31:0] write_addr_o;
   logic [31:0] write_data_o;
   logic        write_enable_o;
   logic        core_rst_o;
   logic        done_o;
   logic        error_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];

   typedef struct {
      int          nbytes;
      logic [7:0]  bytes [12];
      int          nwr;
      logic [31:0] wdata [3];
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   vec_t vecs [6];

   instr_mem_loader #(
      .BASE_ADDR(32'h0000_0000),
      .MEM_SIZE_BYTES(32'h0001_0000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .rx_data_i(rx_data_i),
      .rx_valid_i(rx_valid_i),
      .rx_ready_o(rx_ready_o),
      .write_addr_o(write_addr_o),
      .write_data_o(write_data_o),
      .write_enable_o(write_enable_o),
      .core_rst_o(core_rst_o),
      .done_o(done_o),
      .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // write-port monitor: every strobe must match the next scoreboard entry
   always @(negedge clk_i) begin
      if (!rst_i && write_enable_o) begin
         check("ready_low_in_write", {31'd0, rx_ready_o}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", write_addr_o, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", write_addr_o, e.addr);
            check("write_data", write_data_o, e.data);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // present a byte and hold it until accepted; valid stays high for back-to-back bytes
   task automatic send(input logic [7:0] b);
      int bound;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      bound = 0;
      while (!rx_ready_o && bound < 100) begin
         @(negedge clk_i);
         bound++;
      end
      if (bound >= 100) check("ready_timeout", 32'd0, 32'd1);
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      rx_valid_i = 1'b0;
      for (int i = 0; i < n; i++) @(negedge clk_i);
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic set_bytes(input int v, input int n, input logic [95:0] packed_bytes);
      vecs[v].nbytes = n;
      for (int i = 0; i < 12; i++) vecs[v].bytes[i] = packed_bytes[95-8*i -: 8];
   endtask

   initial begin
      // 1: two full words
      set_bytes(0, 12, 96'h08000000_93001000_13012000);
      vecs[0].nwr = 2; vecs[0].wdata[0] = 32'h0010_0093; vecs[0].wdata[1] = 32'h0020_0113;
      vecs[0].wdata[2] = 0; vecs[0].exp_done = 1; vecs[0].exp_err = 0;
      // 2: partial final word zero-padded
      set_bytes(1, 9, 96'h05000000_AABBCCDD_EE000000);
      vecs[1].nwr = 2; vecs[1].wdata[0] = 32'hDDCC_BBAA; vecs[1].wdata[1] = 32'h0000_00EE;
      vecs[1].wdata[2] = 0; vecs[1].exp_done = 1; vecs[1].exp_err = 0;
      // 3: empty image
      set_bytes(2, 4, 96'h00000000_00000000_00000000);
      vecs[2].nwr = 0; vecs[2].wdata = '{0, 0, 0}; vecs[2].exp_done = 1; vecs[2].exp_err = 0;
      // 4: oversize header, trailing bytes must be ignored
      set_bytes(3, 8, 96'h04000100_11223344_00000000);
      vecs[3].nwr = 0; vecs[3].wdata = '{0, 0, 0}; vecs[3].exp_done = 0; vecs[3].exp_err = 1;
      // 5: one byte past the limit
      set_bytes(4, 6, 96'h01000100_55660000_00000000);
      vecs[4].nwr = 0; vecs[4].wdata = '{0, 0, 0}; vecs[4].exp_done = 0; vecs[4].exp_err = 1;
      // 6: three words, single-byte tail
      set_bytes(5, 13 - 1, 96'h09000000_01020304_05060708);
      vecs[5].nbytes = 12; vecs[5].nwr = 2; vecs[5].wdata[0] = 32'h0403_0201;
      vecs[5].wdata[1] = 32'h0807_0605; vecs[5].wdata[2] = 0;
      vecs[5].exp_done = 0; vecs[5].exp_err = 0;

      do_reset();
      check("rst_ready", {31'd0, rx_ready_o}, 32'd1);
      check("rst_we", {31'd0, write_enable_o}, 32'd0);
      check("rst_addr", write_addr_o, 32'h0);
      check("rst_data", write_data_o, 32'h0);
      check("rst_core_rst", {31'd0, core_rst_o}, 32'd1);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_error", {31'd0, error_o}, 32'd0);

      // no header byte yet: timer must not run
      idle(40);
      check("no_hdr_no_timeout", {31'd0, error_o}, 32'd0);

      for (int v = 0; v < 5; v++) begin
         int bound;
         do_reset();
         for (int w = 0; w < vecs[v].nwr; w++) push_wr(32'(4 * w), vecs[v].wdata[w]);
         for (int i = 0; i < vecs[v].nbytes; i++) begin
            send(vecs[v].bytes[i]);
            if (v == 2 && i == 3) check("empty_done_next_cycle", {31'd0, done_o}, 32'd1);
         end
         idle(1);
         bound = 0;
         while (!done_o && !error_o && bound < 50) begin
            @(negedge clk_i);
            bound++;
         end
         check("vec_done", {31'd0, done_o}, {31'd0, vecs[v].exp_done});
         check("vec_error", {31'd0, error_o}, {31'd0, vecs[v].exp_err});
         check("vec_core_rst", {31'd0, core_rst_o}, {31'd0, ~vecs[v].exp_done});
         // sticky final state, extra bytes discarded
         send(8'hA5); send(8'h5A);
         idle(3);
         check("vec_sticky_done", {31'd0, done_o}, {31'd0, vecs[v].exp_done});
         check("vec_sticky_err", {31'd0, error_o}, {31'd0, vecs[v].exp_err});
         check("vec_pending_writes", 32'(exp_q.size()), 32'd0);
      end

      // timeout with a partial word pending: no write, error after exactly 16 idle cycles
      do_reset();
      send(8'h08); send(8'h00); send(8'h00); send(8'h00);
      send(8'h11); send(8'h22);
      idle(15);
      check("timeout_not_yet", {31'd0, error_o}, 32'd0);
      idle(1);
      check("timeout_error", {31'd0, error_o}, 32'd1);
      check("timeout_core_rst", {31'd0, core_rst_o}, 32'd1);
      idle(4);
      check("timeout_no_write", 32'(exp_q.size()), 32'd0);

      // reset mid-DATA after the first word has been written
      do_reset();
      push_wr(32'h0, vecs[5].wdata[0]);
      push_wr(32'h4, vecs[5].wdata[1]);
      for (int i = 0; i < 10; i++) send(vecs[5].bytes[i]);
      check("mid_first_word", write_data_o, 32'h0403_0201);
      do_reset();
      check("mid_rst_addr", write_addr_o, 32'h0);
      check("mid_rst_data", write_data_o, 32'h0);
      check("mid_rst_we", {31'd0, write_enable_o}, 32'd0);
      check("mid_rst_core_rst", {31'd0, core_rst_o}, 32'd1);
      check("mid_rst_ready", {31'd0, rx_ready_o}, 32'd1);
      exp_q.delete();
      // fresh load after the interrupted one
      push_wr(32'h0, 32'h0010_0093);
      push_wr(32'h4, 32'h0020_0113);
      for (int i = 0; i < 12; i++) send(vecs[0].bytes[i]);
      idle(3);
      check("fresh_done", {31'd0, done_o}, 32'd1);
      check("fresh_core_rst", {31'd0, core_rst_o}, 32'd0);
      check("fresh_pending", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
